// File: rtl/led_pwm_array.sv
// Multi-channel LED driver: a shared prescaler and phase counter feed
// per-channel OFF / ON / PWM / BLINK output logic. Channels are
// configured one at a time through a valid/ready write port that
// accepts at most one write every two cycles.
module led_pwm_array #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8,
  parameter int DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [CNT_W-1:0]     cfg_duty,
  output logic [(2**CH_W)-1:0] led,
  output logic                 tick
);

  localparam int CH = 2 ** CH_W;
  // A divide-by-1 prescaler still needs a one-bit counter to stay legal.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  logic [PW-1:0]    presc_reg;
  logic [CNT_W-1:0] pwm_cnt_reg;
  state_e           state_reg;
  logic             cfg_ready_reg;
  logic             tick_int;
  logic             wrap_int;
  logic             accept;

  assign tick_int  = (presc_reg == PRE_LAST);
  // With DIV=1 the count already sits at its last value during reset, so
  // the strobe is masked while rst is high to keep it quiet in reset.
  assign tick      = tick_int & ~rst;
  // End of a full PWM period: the edge where the phase counter wraps.
  assign wrap_int  = tick_int && (pwm_cnt_reg == CNT_LAST);
  assign accept    = cfg_valid && (state_reg == ST_IDLE);
  assign cfg_ready = cfg_ready_reg;

  // Prescaler: free-running 0..DIV-1 count, wraps on the strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (tick_int) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Shared PWM phase counter, advances once per prescaler strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_reg <= '0;
    end else if (tick_int) begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  // Config handshake FSM: one accepted write, then one dead cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cfg_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cfg_valid) begin
            state_reg     <= ST_APPLY;
            cfg_ready_reg <= 1'b0;
          end
        end
        ST_APPLY: begin
          state_reg     <= ST_IDLE;
          cfg_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= ST_IDLE;
          cfg_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    mode_e            mode_reg;
    logic [CNT_W-1:0] duty_reg;
    logic             blink_reg;
    logic             led_reg;
    logic             sel;

    assign sel     = accept && (cfg_ch == CH_W'(gi));
    assign led[gi] = led_reg;

    // Channel configuration, loaded only by a write addressed here.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_reg <= MODE_OFF;
        duty_reg <= '0;
      end else if (sel) begin
        mode_reg <= mode_e'(cfg_mode);
        duty_reg <= cfg_duty;
      end
    end

    // Blink phase: restarts in the off phase on every write to this
    // channel, otherwise flips once per full PWM period in BLINK mode.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        blink_reg <= 1'b0;
      end else if (sel) begin
        blink_reg <= 1'b0;
      end else if ((mode_reg == MODE_BLINK) && wrap_int) begin
        blink_reg <= ~blink_reg;
      end
    end

    // Registered LED drive derived from the current channel state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        led_reg <= 1'b0;
      end else begin
        case (mode_reg)
          MODE_OFF:   led_reg <= 1'b0;
          MODE_ON:    led_reg <= 1'b1;
          MODE_PWM:   led_reg <= (pwm_cnt_reg < duty_reg);
          MODE_BLINK: led_reg <= blink_reg;
          default:    led_reg <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_array.sv
// Directed bench for led_pwm_array (CH_W=2, CNT_W=8, DIV=4). Expected
// LED vectors for each configuration write are queued when the write is
// driven and compared one edge after the accept edge.
`timescale 1ns/1ps
module tb_led_pwm_array;

  localparam int CH_W  = 2;
  localparam int CNT_W = 8;
  localparam int DIV   = 4;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_duty;
  logic [3:0]       led;
  logic             tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;
    logic [3:0] mask;
  } sb_t;

  sb_t sb[$];

  // Bench model of which LED bits are statically predictable.
  logic [3:0] known;
  logic [3:0] kval;

  led_pwm_array #(
    .CH_W (CH_W),
    .CNT_W(CNT_W),
    .DIV  (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_duty (cfg_duty),
    .led      (led),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and let the registered outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void build_exp(output logic [3:0] e, output logic [3:0] m);
    e = '0;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (known[i]) begin
        m[i] = 1'b1;
        e[i] = kval[i];
      end
    end
  endfunction

  function automatic void model_write(input int ch, input logic [1:0] mode, input logic [7:0] duty);
    case (mode)
      2'b00: begin known[ch] = 1'b1; kval[ch] = 1'b0; end
      2'b01: begin known[ch] = 1'b1; kval[ch] = 1'b1; end
      2'b10: begin known[ch] = (duty == 8'd0); kval[ch] = 1'b0; end
      default: begin known[ch] = 1'b1; kval[ch] = 1'b0; end
    endcase
  endfunction

  task automatic pop_check();
    sb_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, 32'(led & e.mask), 32'(e.exp));
    end
  endtask

  // One configuration write from an idle FSM, with handshake and latency checks.
  task automatic do_write(input int ch, input logic [1:0] mode, input logic [7:0] duty, input string tag);
    sb_t  e;
    logic old_known;
    logic old_val;
    old_known = known[ch];
    old_val   = kval[ch];
    $display("write %s: ch=%0d mode=%0d duty=%0d t=%0t", tag, ch, mode, duty, $time);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = mode;
    cfg_duty  = duty;
    model_write(ch, mode, duty);
    build_exp(e.exp, e.mask);
    e.tag = {tag, "_led"};
    sb.push_back(e);
    check({tag, "_ready_pre"}, 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    check({tag, "_ready_busy"}, 32'(cfg_ready), 32'd0);
    if (old_known) check({tag, "_led_not_yet"}, 32'(led[ch]), 32'(old_val));
    step();
    check({tag, "_ready_back"}, 32'(cfg_ready), 32'd1);
    pop_check();
  endtask

  task automatic count_high(input int b, input int n, output int hi);
    hi = 0;
    for (int c = 0; c < n; c++) begin
      if (led[b]) hi++;
      step();
    end
  endtask

  task automatic wait_led(input int b, input logic v, input int limit, output int n);
    n = 0;
    while ((led[b] !== v) && (n < limit)) begin
      step();
      n++;
    end
  endtask

  logic [1:0] burst_mode [6] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
  int         burst_ch   [6] = '{3, 0, 2, 1, 3, 0};

  initial begin
    int   n;
    int   hi;
    int   acc;
    logic [5:0] acc_pat;
    sb_t  e;

    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_duty  = '0;
    known     = 4'hF;
    kval      = 4'h0;

    // Reset values.
    #2;
    check("rst_led", 32'(led), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_tick", 32'(tick), 32'd0);
    #10;
    rst = 1'b0;

    // First strobe is high in the cycle ending at the 4th edge, i.e.
    // visible right after the 3rd edge; then every 4 cycles, one cycle wide.
    step();
    n = 1;
    while (!tick && n < 20) begin step(); n++; end
    check("first_tick_edge", 32'(n), 32'(DIV - 1));
    step();
    check("tick_one_cycle", 32'(tick), 32'd0);
    n = 1;
    while (!tick && n < 20) begin step(); n++; end
    check("tick_period", 32'(n), 32'(DIV));

    // ON channel.
    do_write(0, 2'b01, 8'd0, "ch0_on");

    // PWM duty sweep over exactly one period.
    do_write(1, 2'b10, 8'd64, "ch1_pwm64");
    count_high(1, 1024, hi);
    check("pwm64_high", 32'(hi), 32'd256);
    do_write(1, 2'b10, 8'd0, "ch1_pwm0");
    count_high(1, 1024, hi);
    check("pwm0_high", 32'(hi), 32'd0);
    do_write(1, 2'b10, 8'd255, "ch1_pwm255");
    count_high(1, 1024, hi);
    check("pwm255_high", 32'(hi), 32'd1020);

    // BLINK starts low, toggles every 1024 cycles, restarts low on rewrite.
    do_write(2, 2'b11, 8'd0, "ch2_blink");
    known[2] = 1'b0;
    wait_led(2, 1'b1, 1100, n);
    check("blink_rise_seen", 32'(n < 1100), 32'd1);
    wait_led(2, 1'b0, 1100, n);
    check("blink_high_time", 32'(n), 32'd1024);
    wait_led(2, 1'b1, 1100, n);
    check("blink_rise2_seen", 32'(n < 1100), 32'd1);
    for (int i = 0; i < 10; i++) step();
    check("blink_high_before_rewrite", 32'(led[2]), 32'd1);
    do_write(2, 2'b11, 8'd0, "ch2_blink_rewrite");
    known[2] = 1'b0;

    // Back-to-back requests: only alternate edges accept.
    acc     = 0;
    acc_pat = '0;
    for (int j = 0; j < 6; j++) begin
      cfg_valid = 1'b1;
      cfg_ch    = 2'(burst_ch[j]);
      cfg_mode  = burst_mode[j];
      cfg_duty  = 8'd0;
      if (j % 2 == 0) model_write(burst_ch[j], burst_mode[j], 8'd0);
      acc_pat[j] = cfg_ready;
      if (cfg_ready) acc++;
      $display("burst req %0d: ch=%0d mode=%0d ready=%0d", j, burst_ch[j], burst_mode[j], cfg_ready);
      step();
    end
    cfg_valid = 1'b0;
    build_exp(e.exp, e.mask);
    e.tag = "burst_led";
    sb.push_back(e);
    check("burst_accepts", 32'(acc), 32'd3);
    check("burst_pattern", 32'(acc_pat), 32'h15);
    pop_check();

    // Reset in the middle of a write while the PWM channel is high.
    wait_led(1, 1'b1, 20, n);
    check("pwm_high_before_rst", 32'(led[1]), 32'd1);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_mode  = 2'b01;
    $display("write inflight: ch=3 mode=1 interrupted by reset t=%0t", $time);
    step();
    cfg_valid = 1'b0;
    check("inflight_apply", 32'(cfg_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_ready", 32'(cfg_ready), 32'd1);
    check("async_rst_tick", 32'(tick), 32'd0);
    #10;
    rst = 1'b0;
    step();
    check("post_rst_ready", 32'(cfg_ready), 32'd1);
    n = 0;
    for (int c = 0; c < 1030; c++) begin
      if (led != 4'b0000) n++;
      step();
    end
    check("post_rst_all_off", 32'(n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_array.md
LED_PWM_ARRAY -- requirements
Module: led_pwm_array

Interface
- REQ-001: Parameter CH_W, default 2: channel index width; channel count CH = 2**CH_W.
- REQ-002: Parameter CNT_W, default 8: PWM phase counter and duty width.
- REQ-003: Parameter DIV, default 4: prescaler divide ratio, legal range 1..65535.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst  input  1  reset, asynchronous, active-high.
- REQ-006: cfg_valid  input  1  configuration write request.
- REQ-007: cfg_ready  output  1  block can accept a configuration write.
- REQ-008: cfg_ch  input  CH_W  target channel of the write.
- REQ-009: cfg_mode  input  2  channel mode: 00 OFF, 01 ON, 10 PWM, 11 BLINK.
- REQ-010: cfg_duty  input  CNT_W  PWM duty value; written in every mode, used only in PWM mode.
- REQ-011: led  output  CH  registered per-channel LED drive, bit i = channel i.
- REQ-012: tick  output  1  one-cycle prescaler strobe.

Function
- REQ-013: Prescaler counts 0..DIV-1 and wraps; tick = 1 during the cycle the count equals DIV-1; DIV=1 gives tick every cycle.
- REQ-014: Phase counter pwm_cnt (CNT_W bits) increments by 1 on each tick cycle and wraps from 2**CNT_W-1 to 0; it is shared by all channels.
- REQ-015: Config FSM has two states: IDLE (cfg_ready=1) and APPLY (cfg_ready=0).
- REQ-016: In IDLE, cfg_valid=1 at an edge accepts the write: mode[cfg_ch] and duty[cfg_ch] load at that edge, and the FSM goes to APPLY.
- REQ-017: APPLY returns to IDLE unconditionally on the next edge; cfg_valid during APPLY is ignored, so at most one write is accepted per 2 cycles.
- REQ-018: A write changes only the addressed channel; other channels' mode, duty, blink state and led are unaffected.
- REQ-019: led[i] is registered from the channel state: OFF -> 0; ON -> 1; PWM -> (pwm_cnt < duty[i]); BLINK -> blink[i].
- REQ-020: Latency: config loaded at edge k shows on led at edge k+1.
- REQ-021: blink[i] toggles at each edge where tick=1 and pwm_cnt=2**CNT_W-1, while channel i is in BLINK mode.
- REQ-022: blink[i] clears to 0 on any accepted write to channel i, so BLINK always starts in the off phase.
- REQ-023: PWM duty=0 gives led permanently 0.
- REQ-024: PWM duty=2**CNT_W-1 gives led low only while pwm_cnt=2**CNT_W-1.
- REQ-025: The PWM period is DIV*2**CNT_W cycles; the high time is duty*DIV cycles.
- REQ-026: Counters free-run regardless of mode or config activity; a write never resets pwm_cnt or the prescaler.

Reset
- REQ-027: While rst=1, all state clears asynchronously: led=0, tick=0, prescaler=0, pwm_cnt=0, all modes OFF, all duties 0, all blink bits 0, FSM in IDLE with cfg_ready=1.
- REQ-028: Reset asserted mid-operation (including during APPLY) discards any in-flight write and forces the REQ-027 values immediately, without waiting for a clock edge.
- REQ-029: After rst falls, the first tick occurs on the DIV-th rising edge.

Verification (CH_W=2, CNT_W=8, DIV=4; PWM period 1024 cycles)
- REQ-030: Reset: hold rst=1 for 10 ns -> led=4'b0000, cfg_ready=1, tick=0; tick period = 4 cycles after release.
- REQ-031: Write ch0 mode=01 -> led[0]=1 one edge after the accept edge; led[3:1] stay 0; cfg_ready is 0 for exactly 1 cycle.
- REQ-032: Write ch1 mode=10 duty=64 -> led[1] high 256 of every 1024 cycles; duty=0 gives always 0; duty=255 gives high 1020 of 1024 cycles.
- REQ-033: Write ch2 mode=11 -> led[2]=0, then toggles every 1024 cycles; rewriting BLINK mid-high returns led[2] to 0 one edge later.
- REQ-034: Hold cfg_valid=1 for 6 cycles with varying cfg_ch -> exactly 3 writes accepted, on alternate edges.
- REQ-035: Assert rst mid-PWM with led[1]=1 -> led=0 and cfg_ready=1 before the next clk edge; all channels read OFF after release.
